// File: rtl/math_adder_seq_ctrl.sv
// Wide adder sequencer: one N*WORDS-bit add, one N-bit chunk per cycle through a shared external adder.
// Optional subtract mode: define MATH_ADDER_SEQ_SUB_EN to add the i_sub port (A - B via ~B and carry-in 1).
//
// state | meaning
// IDLE  | ready for a request; adder outputs forced to 0
// CALC  | one chunk per cycle, LSB first, carry chained through carry_q
// DONE  | result valid and held until i_ready
module math_adder_seq_ctrl #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
`ifdef MATH_ADDER_SEQ_SUB_EN
    input  logic                 i_sub,
`endif
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [N*WORDS-1:0]   i_a,
    input  logic [N*WORDS-1:0]   i_b,
    input  logic                 i_cin,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [N*WORDS-1:0]   o_sum,
    output logic                 o_carry,
    output logic                 o_busy,
    output logic [N-1:0]         o_add_a,
    output logic [N-1:0]         o_add_b,
    output logic                 o_add_cin,
    input  logic [N-1:0]         i_add_sum,
    input  logic                 i_add_carry
);

    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            carry_q;
    logic            carry_out_q;
    logic [IW-1:0]   idx;
    logic            last_chunk;
    logic [N-1:0]    a_chunk;
    logic [N-1:0]    b_chunk;
    logic            carry_init;

`ifdef MATH_ADDER_SEQ_SUB_EN
    logic            sub_q;
    assign carry_init = i_sub ? 1'b1 : i_cin;
`else
    assign carry_init = i_cin;
`endif

    assign last_chunk = (idx == IW'(WORDS - 1));
    assign a_chunk    = a_q[int'(idx)*N +: N];
    assign b_chunk    = b_q[int'(idx)*N +: N];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            idx         <= '0;
`ifdef MATH_ADDER_SEQ_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_q     <= i_a;
                        b_q     <= i_b;
                        carry_q <= carry_init;
                        idx     <= '0;
`ifdef MATH_ADDER_SEQ_SUB_EN
                        sub_q   <= i_sub;
`endif
                    end
                end
                CALC: begin
                    sum_q[int'(idx)*N +: N] <= i_add_sum;
                    carry_q                 <= i_add_carry;
                    idx                     <= idx + IW'(1);
                    if (last_chunk) begin
                        carry_out_q <= i_add_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_valid) state_nxt = CALC;
            CALC:    if (last_chunk) state_nxt = DONE;
            DONE:    if (i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_add_a   = '0;
        o_add_b   = '0;
        o_add_cin = 1'b0;
        if (state == CALC) begin
            o_add_a   = a_chunk;
`ifdef MATH_ADDER_SEQ_SUB_EN
            o_add_b   = sub_q ? ~b_chunk : b_chunk;
`else
            o_add_b   = b_chunk;
`endif
            o_add_cin = carry_q;
        end
    end

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign o_busy  = (state != IDLE);
    assign o_sum   = sum_q;
    assign o_carry = carry_out_q;

endmodule

// File: tb/tb_math_adder_seq_ctrl.sv
// Bench for math_adder_seq_ctrl: directed test-plan steps plus random ops against an arithmetic reference.
// Define MATH_ADDER_SEQ_SUB_EN for both files to exercise subtract mode.
module tb_math_adder_seq_ctrl;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic           i_clk;
    logic           i_rst_n;
    logic           i_valid;
    logic           o_ready;
    logic [W-1:0]   i_a;
    logic [W-1:0]   i_b;
    logic           i_cin;
    logic           o_valid;
    logic           i_ready;
    logic [W-1:0]   o_sum;
    logic           o_carry;
    logic           o_busy;
    logic [N-1:0]   o_add_a;
    logic [N-1:0]   o_add_b;
    logic           o_add_cin;
    logic [N-1:0]   i_add_sum;
    logic           i_add_carry;
`ifdef MATH_ADDER_SEQ_SUB_EN
    logic           i_sub;
`endif

    int tests_run;
    int tests_failed;

    math_adder_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
`ifdef MATH_ADDER_SEQ_SUB_EN
        .i_sub       (i_sub),
`endif
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_cin       (i_cin),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_sum       (o_sum),
        .o_carry     (o_carry),
        .o_busy      (o_busy),
        .o_add_a     (o_add_a),
        .o_add_b     (o_add_b),
        .o_add_cin   (o_add_cin),
        .i_add_sum   (i_add_sum),
        .i_add_carry (i_add_carry)
    );

    // External combinational chunk adder
    assign {i_add_carry, i_add_sum} = {1'b0, o_add_a} + {1'b0, o_add_b} + {{N{1'b0}}, o_add_cin};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 64'(o_ready), 64'd1);
        check({tag, "_valid"}, 64'(o_valid), 64'd0);
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
        check({tag, "_adda"}, 64'(o_add_a), 64'd0);
        check({tag, "_addb"}, 64'(o_add_b), 64'd0);
        check({tag, "_addcin"}, 64'(o_add_cin), 64'd0);
    endtask

    task automatic wait_ready(input string tag);
        int guard;
        guard = 0;
        while (o_ready !== 1'b1 && guard < 20) begin
            @(negedge i_clk);
            guard++;
        end
        check({tag, "_accept_wait"}, 64'(o_ready), 64'd1);
    endtask

    // One full operation. Cycle 0 is the IDLE cycle whose closing edge accepts the request.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input int hold);
        logic [W-1:0] bb;
        logic         c0;
        logic [W:0]   full;
        logic [63:0]  mask;
        logic [63:0]  lo;
        bb   = sub ? ~b : b;
        c0   = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + (W+1)'(c0);
        i_a = a;
        i_b = b;
        i_cin = cin;
`ifdef MATH_ADDER_SEQ_SUB_EN
        i_sub = sub;
`endif
        i_valid = 1'b1;
        i_ready = (hold == 0);
        wait_ready(tag);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_a = W'($urandom);
        i_b = W'($urandom);
        i_cin = 1'($urandom);
`ifdef MATH_ADDER_SEQ_SUB_EN
        i_sub = 1'($urandom);
`endif
        for (int k = 0; k < WORDS; k++) begin
            mask = (64'd1 << (k * N)) - 64'd1;
            lo   = (64'(a) & mask) + (64'(bb) & mask) + 64'(c0);
            check({tag, "_calc_busy"}, 64'(o_busy), 64'd1);
            check({tag, "_calc_ready"}, 64'(o_ready), 64'd0);
            check({tag, "_calc_valid"}, 64'(o_valid), 64'd0);
            check({tag, "_calc_adda"}, 64'(o_add_a), 64'(a[k*N +: N]));
            check({tag, "_calc_addb"}, 64'(o_add_b), 64'(bb[k*N +: N]));
            check({tag, "_calc_addcin"}, 64'(o_add_cin), 64'(lo[k*N]));
            @(negedge i_clk);
        end
        check({tag, "_done_valid"}, 64'(o_valid), 64'd1);
        check({tag, "_done_sum"}, 64'(o_sum), 64'(full[W-1:0]));
        check({tag, "_done_carry"}, 64'(o_carry), 64'(full[W]));
        check({tag, "_done_adda"}, 64'(o_add_a), 64'd0);
        for (int h = 0; h < hold; h++) begin
            i_valid = (h == 2);
            @(negedge i_clk);
            check({tag, "_hold_valid"}, 64'(o_valid), 64'd1);
            check({tag, "_hold_ready"}, 64'(o_ready), 64'd0);
            check({tag, "_hold_sum"}, 64'(o_sum), 64'(full[W-1:0]));
            check({tag, "_hold_carry"}, 64'(o_carry), 64'(full[W]));
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        check_idle_outputs({tag, "_after"});
        check({tag, "_after_sum"}, 64'(o_sum), 64'(full[W-1:0]));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_a     = '0;
        i_b     = '0;
        i_cin   = 1'b0;
`ifdef MATH_ADDER_SEQ_SUB_EN
        i_sub   = 1'b0;
`endif
        repeat (2) @(negedge i_clk);
        check_idle_outputs("reset");
        check("reset_sum", 64'(o_sum), 64'd0);
        check("reset_carry", 64'(o_carry), 64'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        run_op("carry_chunk", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op("all_ones_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
        run_op("backpressure", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 6);

        // Reset during the second CALC cycle
        i_a = 32'hA5A5_A5A5;
        i_b = 32'h5A5A_5A5A;
        i_cin = 1'b1;
        i_valid = 1'b1;
        i_ready = 1'b1;
        wait_ready("midreset");
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset_low");
        check("midreset_sum", 64'(o_sum), 64'd0);
        check("midreset_carry", 64'(o_carry), 64'd0);
        @(negedge i_clk);
        check_idle_outputs("midreset_low2");
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_idle_outputs("midreset_rel");
        run_op("post_reset", 32'd3, 32'd4, 1'b0, 1'b0, 0);

        // Back-to-back with i_valid held high
        i_a = 32'd1;
        i_b = 32'd2;
        i_cin = 1'b0;
        i_valid = 1'b1;
        i_ready = 1'b1;
        wait_ready("b2b");
        @(negedge i_clk);
        i_a = 32'h8000_0000;
        i_b = 32'h8000_0000;
        repeat (4) @(negedge i_clk);
        check("b2b_1_valid", 64'(o_valid), 64'd1);
        check("b2b_1_sum", 64'(o_sum), 64'd3);
        check("b2b_1_carry", 64'(o_carry), 64'd0);
        @(negedge i_clk);
        check("b2b_accept2_ready", 64'(o_ready), 64'd1);
        check("b2b_accept2_valid", 64'(o_valid), 64'd0);
        @(negedge i_clk);
        i_valid = 1'b0;
        check("b2b_2_busy", 64'(o_busy), 64'd1);
        repeat (4) @(negedge i_clk);
        check("b2b_2_valid", 64'(o_valid), 64'd1);
        check("b2b_2_sum", 64'(o_sum), 64'd0);
        check("b2b_2_carry", 64'(o_carry), 64'd1);
        @(negedge i_clk);
        check_idle_outputs("b2b_end");

`ifdef MATH_ADDER_SEQ_SUB_EN
        run_op("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 0);
        run_op("sub_pos", 32'd7, 32'd5, 1'b1, 1'b1, 0);
`endif

        for (int r = 0; r < 20; r++) begin
            logic sub_r;
`ifdef MATH_ADDER_SEQ_SUB_EN
            sub_r = 1'($urandom);
`else
            sub_r = 1'b0;
`endif
            run_op("random", W'($urandom), W'($urandom), 1'($urandom), sub_r,
                   int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/math_adder_seq_ctrl.md
Name: math_adder_seq_ctrl

Overview:
- Sequencer that performs one wide addition (N*WORDS bits) by time-multiplexing a single external N-bit combinational adder (Brent-Kung class), one chunk per cycle, LSB chunk first.
- Carry is chained between chunks through an internal register.
- Sits between a valid/ready requester and the shared adder datapath; the adder itself is not instantiated here.

Parameters:
- N, 8, chunk width (external adder width).
- WORDS, 4, number of chunks; total operand width W = N*WORDS; WORDS >= 2.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  request valid.
- o_ready  output  1  request ready.
- i_a  input  W  operand A.
- i_b  input  W  operand B.
- i_cin  input  1  carry-in for chunk 0.
- o_valid  output  1  result valid.
- i_ready  input  1  result consumer ready.
- o_sum  output  W  result sum.
- o_carry  output  1  final carry-out.
- o_busy  output  1  high whenever state != IDLE.
- o_add_a  output  N  chunk of A driven to the external adder.
- o_add_b  output  N  chunk of B driven to the external adder.
- o_add_cin  output  1  carry driven to the external adder.
- i_add_sum  input  N  external adder sum.
- i_add_carry  input  1  external adder carry-out.

Behaviour:
- Clock/reset: single clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values:
  - State = IDLE; o_ready = 1.
  - o_valid, o_busy, o_carry = 0; o_sum = 0.
  - o_add_a, o_add_b, o_add_cin = 0.
  - Operand registers, chunk index and carry register all cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - o_ready = 1.
  - On i_valid & o_ready, capture i_a, i_b into operand registers and i_cin into the carry register; clear idx to 0; go to CALC.
- CALC:
  - o_ready = 0.
  - Adder drives: o_add_a = A[idx*N +: N], o_add_b = B[idx*N +: N], o_add_cin = carry register.
  - Each cycle, register i_add_sum into o_sum[idx*N +: N] and i_add_carry into the carry register; idx increments.
  - When idx == WORDS-1, also load o_carry from i_add_carry and go to DONE.
- DONE:
  - o_valid = 1; o_sum and o_carry held stable.
  - On i_ready, go to IDLE (o_valid drops the next cycle).
  - No new request can be accepted while in DONE (o_ready = 0).
- Adder-side outputs are 0 outside CALC. The external adder is combinational; its result is sampled in the same cycle it is driven.
- Latency:
  - Accept edge at cycle T.
  - CALC occupies cycles T+1..T+WORDS.
  - o_valid rises at T+WORDS+1.
  - Back-to-back throughput is one op per WORDS+2 cycles when i_ready is held high.
- o_sum between operations:
  - Retains the last result until overwritten chunk-wise by the next CALC.
  - o_sum is only meaningful while o_valid = 1.
- i_valid handling: ignored outside IDLE; operands are captured only on the accept edge, so input changes afterwards have no effect.
- Width rules: arithmetic is modulo 2^W; o_carry is bit W of A + B + cin.
- Reset mid-operation (any state): immediate return to reset values; the in-flight operation is discarded, with no partial o_valid.
- Simultaneous events: i_valid in the same cycle as a DONE->IDLE transition is not accepted; it is accepted in the following IDLE cycle.

Optional Feature:
- Macro: MATH_ADDER_SEQ_SUB_EN.
- When defined:
  - Extra port i_sub (input, 1), captured at accept.
  - If i_sub = 1: o_add_b = ~B chunk and the initial carry register = 1 (i_cin ignored), giving A - B.
  - o_carry = 1 means no borrow.
  - If i_sub = 0: addition as above.
- When not defined: no i_sub port; addition only, and logic is identical to the baseline.

Test Plan (N=8, WORDS=4, bench models the external adder as a combinational 8-bit adder):
- a=0x000000FF, b=0x00000001, cin=0, i_ready=1 -> o_sum=0x00000100, o_carry=0, o_valid rises exactly 5 cycles after the accept edge, high for 1 cycle.
- a=0xFFFFFFFF, b=0x00000000, cin=1 -> o_sum=0x00000000, o_carry=1; o_add_cin=1 on every CALC cycle.
- Backpressure: a=0x12345678, b=0x11111111, i_ready=0 for 6 cycles after o_valid -> o_sum=0x23456789 held stable, o_ready=0 throughout, a pulsed i_valid is ignored; the result is consumed on the first i_ready=1.
- Reset asserted during the 2nd CALC cycle -> all outputs 0 and o_ready=1 while reset is low; next request a=3, b=4 -> o_sum=7, o_carry=0.
- Back-to-back: i_valid held high with i_ready=1 for two ops (1+2, then 0x80000000+0x80000000) -> results 3/carry 0, then 0/carry 1; the second accept occurs 6 cycles after the first.
- With MATH_ADDER_SEQ_SUB_EN: a=0x00000005, b=0x00000007, i_sub=1 -> o_sum=0xFFFFFFFE, o_carry=0; a=7, b=5, i_sub=1 -> o_sum=2, o_carry=1.
